// File: rtl/alu_serial_slice.sv
// Multi-cycle ALU that processes a WIDTH-bit operation SLICE bits per clock, LSB slice first.
// The carry is chained between cycles in a register. Result and flags are registered and held, with a start/busy/done handshake.
module alu_serial_slice #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_K = CW'(N - 1);

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_OR  = 2'b01;
    localparam logic [1:0] FN_AND = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;        // holds b' (already conditionally inverted)
    logic [WIDTH-1:0] partial_reg;
    logic [1:0]       fn_reg;
    logic             inv_reg;
    logic             carry_reg;
    logic [CW-1:0]    k_reg;

    logic [SLICE-1:0] a_lo;
    logic [SLICE-1:0] b_lo;
    logic [SLICE:0]   sum;
    logic [SLICE-1:0] slice_res;
    logic             is_add;
    logic             add_carry;
    logic             add_ovf;
    logic [WIDTH-1:0] partial_next;

    assign a_lo   = a_reg[SLICE-1:0];
    assign b_lo   = b_reg[SLICE-1:0];
    assign is_add = (fn_reg == FN_ADD);
    assign sum    = {1'b0, a_lo} + {1'b0, b_lo} + {{SLICE{1'b0}}, carry_reg};

    // Signed overflow of the top bit: like-signed operands producing an opposite-signed sum.
    assign add_carry = is_add & sum[SLICE];
    assign add_ovf   = is_add & (a_lo[SLICE-1] == b_lo[SLICE-1]) & (sum[SLICE-1] != a_lo[SLICE-1]);

    // NOT with op[0]=1 yields ~b, which is exactly the latched b'.
    genvar gi;
    generate
        for (gi = 0; gi < SLICE; gi++) begin : g_bit
            assign slice_res[gi] = (fn_reg == FN_ADD) ? sum[gi]
                                 : (fn_reg == FN_OR)  ? (a_lo[gi] | b_lo[gi])
                                 : (fn_reg == FN_AND) ? (a_lo[gi] & b_lo[gi])
                                 : (inv_reg ? b_lo[gi] : ~a_lo[gi]);
        end
    endgenerate

    assign partial_next = WIDTH'({slice_res, partial_reg} >> SLICE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            partial_reg <= '0;
            fn_reg      <= '0;
            inv_reg     <= 1'b0;
            carry_reg   <= 1'b0;
            k_reg       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            carry_out   <= 1'b0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg       <= a;
                        b_reg       <= op[0] ? ~b : b;
                        fn_reg      <= op[2:1];
                        inv_reg     <= op[0];
                        carry_reg   <= (op[2:1] == FN_ADD) & carry_in;
                        k_reg       <= '0;
                        partial_reg <= '0;
                        busy        <= 1'b1;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    a_reg       <= a_reg >> SLICE;
                    b_reg       <= b_reg >> SLICE;
                    partial_reg <= partial_next;
                    carry_reg   <= add_carry;
                    k_reg       <= k_reg + CW'(1);
                    if (k_reg == LAST_K) begin
                        result    <= partial_next;
                        carry_out <= add_carry;
                        zero      <= (partial_next == '0);
                        overflow  <= add_ovf;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_serial_slice.md
Name: alu_serial_slice

Overview:
- Parametrised, multi-cycle successor to the single-bit ALU slice.
- Processes a WIDTH-bit operation SLICE bits per clock, least-significant slice first, and chains the carry between cycles in a register.
- Uses the same opcode set as the slice. Adds registered result, carry, zero and overflow flags, plus a start/busy/done handshake.
- Sits between the datapath register file and the writeback mux wherever area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of SLICE.
- SLICE, 4, bits processed per clock; SLICE == WIDTH gives a single-cycle registered ALU.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  3  op[2:1] selects 00 ADD, 01 OR, 10 AND, 11 NOT; op[0] inverts b.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  initial carry for ADD.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when result and flags become valid.
- result  output  WIDTH  final result, held until the next completion.
- carry_out  output  1  final carry of ADD; 0 for logic ops.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow of ADD; 0 for logic ops.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE; busy, done, result, carry_out, zero, overflow and all internal registers = 0.
- Reset mid-operation aborts immediately: no done pulse, and the result is cleared.
- Let N = WIDTH/SLICE and b' = op[0] ? ~b : b.
- Per-bit function, matching the slice:
  - ADD: a + b' + carry.
  - OR: a | b'.
  - AND: a & b'.
  - NOT: op[0] ? ~b : ~a.
- Subtract is ADD with op[0]=1 and carry_in=1, giving a - b. carry_out=1 means no borrow.
- States:
  - IDLE:
    - start=1 latches a, b', op and carry_in into operand shift registers; clears slice counter and partial result; goes to RUN.
    - start=0 stays in IDLE.
  - RUN:
    - Each edge computes slice k (bits SLICE*k+SLICE-1 : SLICE*k) from the low SLICE bits of the shift registers.
    - Shifts the operands right by SLICE, shifts the slice into the partial result from the top, updates the carry register and increments k.
    - On the edge processing k = N-1: write result, carry_out, zero and overflow; go to DONE.
  - DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- Latency:
  - done is high in the cycle after the N-th edge following the edge that sampled start.
  - Back-to-back issue is possible: start may be asserted in the cycle after done, i.e. in IDLE.
- Handshake:
  - start in RUN or DONE is ignored. There is no queueing, and changes on a, b or op during RUN have no effect.
  - busy rises on the edge that samples start and falls on the edge leaving DONE.
- Flags:
  - carry_out is the carry out of bit WIDTH-1.
  - overflow = carry into bit WIDTH-1 XOR carry_out, for ADD only.
  - zero is evaluated over the full WIDTH result, for all ops.
  - Flags and result change only on the completion edge and hold otherwise.
- Logic ops ignore carry_in; the carry register is forced to 0 for them.
- SLICE == WIDTH: N = 1, RUN lasts one edge, done appears 2 cycles after start.

Test Plan:
- ADD, WIDTH=16, SLICE=4: a=0x1234, b=0x0FFF, op=000, carry_in=0.
  - result=0x2233, carry_out=0, zero=0, overflow=0.
  - done exactly 4 edges after the start edge; busy high for 5 cycles.
- SUB: a=0x0005, b=0x0007, op=001, carry_in=1 → result=0xFFFE, carry_out=0, overflow=0.
- Overflow and zero:
  - a=0x7FFF + b=0x0001, ADD → 0x8000, overflow=1.
  - a=0xFFFF + b=0x0001, ADD → 0x0000, carry_out=1, zero=1, overflow=0.
- Logic ops with a=0xF0F0, b=0x3C3C:
  - AND (100) → 0x3030.
  - OR (010) → 0xFCFC.
  - NOT (110) → 0x0F0F.
  - NOT with op[0]=1 (111) → 0xC3C3.
  - carry_out=0 and overflow=0 for all four.
- Handshake:
  - Pulse start again with different operands on cycles 2 and 4 of an ADD → ignored; the first result is unchanged.
  - Start in the cycle after done → second op accepted.
  - Assert rst_n=0 mid-RUN → all outputs 0 immediately and no done pulse.
- SLICE=WIDTH=8: 0x80 + 0x80 ADD → result=0x00, carry_out=1, overflow=1, zero=1, done 1 edge after the start edge.
